// File: rtl/data_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arb_pkg
// Brief    : Shared types and constants for the data-memory arbiter
// Revision : 1.0
// ============================================================================
package data_mem_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    localparam logic [63:0] ADDR_LIMIT_DEFAULT = 64'h400;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-way round-robin winner selection with a registered pointer
// Revision : 1.0
// ============================================================================
module rr_arbiter2
    import data_mem_arb_pkg::*;
(
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [1:0] i_req,
    input  logic [1:0] i_busy,
    output logic       o_grant,
    output logic       o_winner
);

    logic [1:0] w_elig;
    logic       w_winner;
    logic       r_ptr;

    // A requester in its grant cycle still holds REQ, so it is masked out.
    assign w_elig = i_req & ~i_busy;

    always_comb begin
        w_winner = REQ_CPU;
        case (w_elig)
            2'b01:   w_winner = REQ_CPU;
            2'b10:   w_winner = REQ_AUX;
            2'b11:   w_winner = r_ptr;
            default: w_winner = REQ_CPU;
        endcase
    end

    assign o_grant  = |w_elig;
    assign o_winner = w_winner;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_ptr <= REQ_CPU;
        end else if (o_grant) begin
            r_ptr <= ~w_winner;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Brief    : Round-robin sharing of Data_Memory between CPU and an aux master
// Revision : 1.0
// ============================================================================
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int                ADDR_W     = 64,
    parameter int                DATA_W     = 64,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(ADDR_LIMIT_DEFAULT),
    parameter int                CNT_W      = 16
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA0,
    input  logic [DATA_W-1:0] WDATA1,
    output logic              GNT0,
    output logic              GNT1,
    output logic              RVALID0,
    output logic              RVALID1,
    output logic [DATA_W-1:0] RDATA,
    output logic              ERR,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              control_memwrite,
    output logic              control_memread,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [CNT_W-1:0]  GNT_CNT0,
    output logic [CNT_W-1:0]  GNT_CNT1
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic [1:0]        r_gnt;
    logic [1:0]        r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              r_cmd_id;
    logic              r_cmd_we;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [DATA_W-1:0] r_cmd_wdata;
    logic [CNT_W-1:0]  r_cnt0;
    logic [CNT_W-1:0]  r_cnt1;
    logic              w_grant;
    logic              w_winner;
    logic              w_in_range;
    logic              w_access;

    rr_arbiter2 u_rr (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .i_req    ({REQ1, REQ0}),
        .i_busy   (r_gnt),
        .o_grant  (w_grant),
        .o_winner (w_winner)
    );

    assign w_in_range = (r_cmd_addr < ADDR_LIMIT);
    assign w_access   = (r_state == ST_ACCESS);

    // Every grant opens exactly one ACCESS cycle; back-to-back grants keep us there.
    always_comb begin
        w_state_next     = ST_IDLE;
        control_memwrite = 1'b0;
        control_memread  = 1'b0;
        if (w_grant) begin
            w_state_next = ST_ACCESS;
        end
        if (w_access && w_in_range) begin
            control_memwrite = r_cmd_we;
            control_memread  = ~r_cmd_we;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_gnt       <= 2'b00;
            r_cmd_id    <= REQ_CPU;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
        end else begin
            r_gnt <= 2'b00;
            if (w_grant) begin
                r_gnt[w_winner] <= 1'b1;
                r_cmd_id        <= w_winner;
                r_cmd_we        <= (w_winner == REQ_AUX) ? WE1    : WE0;
                r_cmd_addr      <= (w_winner == REQ_AUX) ? ADDR1  : ADDR0;
                r_cmd_wdata     <= (w_winner == REQ_AUX) ? WDATA1 : WDATA0;
            end
        end
    end

    // Completion of the access that occupied the cycle ending at this edge.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_rvalid <= 2'b00;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= 2'b00;
            r_err    <= 1'b0;
            if (w_access) begin
                r_rvalid[r_cmd_id] <= 1'b1;
                r_err              <= ~w_in_range;
                r_rdata            <= (w_in_range && !r_cmd_we) ? mem_data_out : '0;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_grant) begin
            if (w_winner == REQ_CPU && r_cnt0 != '1) begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
            if (w_winner == REQ_AUX && r_cnt1 != '1) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end
        end
    end

    assign GNT0        = r_gnt[0];
    assign GNT1        = r_gnt[1];
    assign RVALID0     = r_rvalid[0];
    assign RVALID1     = r_rvalid[1];
    assign RDATA       = r_rdata;
    assign ERR         = r_err;
    assign mem_address = r_cmd_addr;
    assign mem_data_in = r_cmd_wdata;
    assign GNT_CNT0    = r_cnt0;
    assign GNT_CNT1    = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Brief    : Directed self-checking bench for data_mem_arbiter
// Revision : 1.0
// ============================================================================
module tb_data_mem_arbiter;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
    logic [63:0] ADDR0 = '0, ADDR1 = '0, WDATA0 = '0, WDATA1 = '0;
    logic        GNT0, GNT1, RVALID0, RVALID1, ERR;
    logic [63:0] RDATA, mem_address, mem_data_in, mem_data_out;
    logic        control_memwrite, control_memread;
    logic [15:0] GNT_CNT0, GNT_CNT1;

    logic        sat_gnt0, sat_gnt1, sat_rvalid0, sat_rvalid1, sat_err;
    logic [63:0] sat_rdata, sat_mem_address, sat_mem_data_in;
    logic [63:0] sat_mem_data_out = '0;
    logic        sat_memwrite, sat_memread;
    logic [1:0]  sat_cnt0, sat_cnt1;

    logic [63:0] mem [0:255];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 CLOCK = ~CLOCK;

    assign mem_data_out = mem[mem_address[10:3]];
    always @(posedge CLOCK) begin
        if (control_memwrite) mem[mem_address[10:3]] = mem_data_in;
    end

    data_mem_arbiter u_dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
        .RDATA(RDATA), .ERR(ERR),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .control_memwrite(control_memwrite), .control_memread(control_memread),
        .mem_data_out(mem_data_out),
        .GNT_CNT0(GNT_CNT0), .GNT_CNT1(GNT_CNT1)
    );

    data_mem_arbiter #(.CNT_W(2)) u_sat (
        .CLOCK(CLOCK), .RESET(RESET),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(sat_gnt0), .GNT1(sat_gnt1), .RVALID0(sat_rvalid0), .RVALID1(sat_rvalid1),
        .RDATA(sat_rdata), .ERR(sat_err),
        .mem_address(sat_mem_address), .mem_data_in(sat_mem_data_in),
        .control_memwrite(sat_memwrite), .control_memread(sat_memread),
        .mem_data_out(sat_mem_data_out),
        .GNT_CNT0(sat_cnt0), .GNT_CNT1(sat_cnt1)
    );

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        RESET = 1'b0;
        REQ0  = 1'b0;
        REQ1  = 1'b0;
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        RESET = 1'b0;
        REQ0  = 1'b1; WE0 = 1'b0; ADDR0 = 64'h8;
        repeat (3) @(posedge CLOCK);
        #1;
        n_cmp++;
        if ({GNT0, GNT1, RVALID0, RVALID1, ERR, control_memwrite, control_memread} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {GNT0, GNT1, RVALID0, RVALID1, ERR, control_memwrite, control_memread});
        end
        n_cmp++;
        if ({RDATA, mem_address, mem_data_in, GNT_CNT0, GNT_CNT1} !== '0) begin
            n_bad++;
            $display("FAIL reset_buses: rdata=%h addr=%h din=%h cnt0=%0d cnt1=%0d required all 0",
                     RDATA, mem_address, mem_data_in, GNT_CNT0, GNT_CNT1);
        end
        @(negedge CLOCK);
        RESET = 1'b1;
        #1;
        n_cmp++;
        if (GNT0 !== 1'b0) begin
            n_bad++; $display("FAIL reset_no_early_gnt: GNT0=%b required 0", GNT0);
        end
        tick();
        n_cmp++;
        if (GNT0 !== 1'b1 || control_memread !== 1'b1) begin
            n_bad++; $display("FAIL reset_first_gnt: GNT0=%b memread=%b required 1 1", GNT0, control_memread);
        end
        @(negedge CLOCK);
        REQ0 = 1'b0;
        tick();
        n_cmp++;
        if (RVALID0 !== 1'b1 || GNT_CNT0 !== 16'd1) begin
            n_bad++; $display("FAIL reset_first_rvalid: RVALID0=%b cnt0=%0d required 1 1", RVALID0, GNT_CNT0);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        mem[2] = 64'hDEAD;
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 64'h10;
        tick();
        n_cmp++;
        if (GNT0 !== 1'b1 || GNT1 !== 1'b0 || control_memread !== 1'b1 || control_memwrite !== 1'b0) begin
            n_bad++;
            $display("FAIL read_gnt: gnt0=%b gnt1=%b rd=%b wr=%b required 1 0 1 0",
                     GNT0, GNT1, control_memread, control_memwrite);
        end
        n_cmp++;
        if (mem_address !== 64'h10) begin
            n_bad++; $display("FAIL read_addr: got %h required 10", mem_address);
        end
        @(negedge CLOCK);
        REQ0 = 1'b0;
        tick();
        n_cmp++;
        if (RVALID0 !== 1'b1 || RVALID1 !== 1'b0 || RDATA !== 64'hDEAD || ERR !== 1'b0) begin
            n_bad++;
            $display("FAIL read_data: rv0=%b rv1=%b rdata=%h err=%b required 1 0 dead 0",
                     RVALID0, RVALID1, RDATA, ERR);
        end
        n_cmp++;
        if (GNT_CNT0 !== 16'd1 || GNT0 !== 1'b0 || control_memread !== 1'b0) begin
            n_bad++;
            $display("FAIL read_after: cnt0=%0d gnt0=%b rd=%b required 1 0 0", GNT_CNT0, GNT0, control_memread);
        end
    endtask

    task automatic test_contention();
        do_reset();
        REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 64'h20; WDATA0 = 64'hA0;
        REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 64'h28; WDATA1 = 64'hB0;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++;
            if (GNT0 !== (k % 2 == 0) || GNT1 !== (k % 2 == 1)) begin
                n_bad++; $display("FAIL cont_gnt[%0d]: gnt0=%b gnt1=%b required %b %b",
                                  k, GNT0, GNT1, (k % 2 == 0), (k % 2 == 1));
            end
            n_cmp++;
            if (control_memwrite !== 1'b1 || mem_address !== ((k % 2 == 0) ? 64'h20 : 64'h28)) begin
                n_bad++; $display("FAIL cont_mem[%0d]: wr=%b addr=%h", k, control_memwrite, mem_address);
            end
            n_cmp++;
            if (RVALID0 !== (k % 2 == 1) || RVALID1 !== (k >= 2 && k % 2 == 0)) begin
                n_bad++; $display("FAIL cont_rvalid[%0d]: rv0=%b rv1=%b required %b %b",
                                  k, RVALID0, RVALID1, (k % 2 == 1), (k >= 2 && k % 2 == 0));
            end
        end
        @(negedge CLOCK);
        REQ0 = 1'b0; REQ1 = 1'b0;
        tick();
        n_cmp++;
        if (RVALID1 !== 1'b1 || GNT0 !== 1'b0 || GNT1 !== 1'b0 || control_memwrite !== 1'b0) begin
            n_bad++; $display("FAIL cont_tail: rv1=%b gnt0=%b gnt1=%b wr=%b required 1 0 0 0",
                              RVALID1, GNT0, GNT1, control_memwrite);
        end
        n_cmp++;
        if (GNT_CNT0 !== 16'd4 || GNT_CNT1 !== 16'd4) begin
            n_bad++; $display("FAIL cont_counts: cnt0=%0d cnt1=%0d required 4 4", GNT_CNT0, GNT_CNT1);
        end
        n_cmp++;
        if (mem[4] !== 64'hA0 || mem[5] !== 64'hB0) begin
            n_bad++; $display("FAIL cont_written: m20=%h m28=%h required a0 b0", mem[4], mem[5]);
        end
    endtask

    task automatic test_blocked();
        do_reset();
        mem[127] = 64'h1234_5678;
        mem[128] = 64'hBAD;
        REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 64'h400; WDATA1 = 64'hFFFF;
        tick();
        n_cmp++;
        if (GNT1 !== 1'b1 || control_memwrite !== 1'b0 || control_memread !== 1'b0) begin
            n_bad++; $display("FAIL blk_gnt: gnt1=%b wr=%b rd=%b required 1 0 0",
                              GNT1, control_memwrite, control_memread);
        end
        @(negedge CLOCK);
        n_cmp++;
        if (control_memwrite !== 1'b0 || control_memread !== 1'b0) begin
            n_bad++; $display("FAIL blk_mid: wr=%b rd=%b required 0 0", control_memwrite, control_memread);
        end
        REQ1 = 1'b0;
        tick();
        n_cmp++;
        if (RVALID1 !== 1'b1 || ERR !== 1'b1 || RDATA !== 64'h0) begin
            n_bad++; $display("FAIL blk_resp: rv1=%b err=%b rdata=%h required 1 1 0", RVALID1, ERR, RDATA);
        end
        @(negedge CLOCK);
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 64'h3F8;
        tick();
        @(negedge CLOCK);
        REQ0 = 1'b0;
        tick();
        n_cmp++;
        if (RVALID0 !== 1'b1 || ERR !== 1'b0 || RDATA !== 64'h1234_5678) begin
            n_bad++; $display("FAIL blk_readback: rv0=%b err=%b rdata=%h required 1 0 12345678",
                              RVALID0, ERR, RDATA);
        end
        n_cmp++;
        if (mem[128] !== 64'hBAD) begin
            n_bad++; $display("FAIL blk_no_write: m400=%h required bad", mem[128]);
        end
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        mem[6] = 64'h5555;
        REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 64'h30; WDATA0 = 64'h9999;
        tick();
        n_cmp++;
        if (control_memwrite !== 1'b1) begin
            n_bad++; $display("FAIL mid_wr_before: wr=%b required 1", control_memwrite);
        end
        #2;
        RESET = 1'b0;
        REQ0  = 1'b0;
        #1;
        n_cmp++;
        if (control_memwrite !== 1'b0 || GNT0 !== 1'b0 || mem_address !== 64'h0) begin
            n_bad++; $display("FAIL mid_wr_drop: wr=%b gnt0=%b addr=%h required 0 0 0",
                              control_memwrite, GNT0, mem_address);
        end
        tick();
        n_cmp++;
        if (mem[6] !== 64'h5555 || RVALID0 !== 1'b0) begin
            n_bad++; $display("FAIL mid_mem_kept: m30=%h rv0=%b required 5555 0", mem[6], RVALID0);
        end
        @(negedge CLOCK);
        RESET = 1'b1;
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 64'h30;
        REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 64'h38;
        #1;
        n_cmp++;
        if (control_memwrite !== 1'b0 || control_memread !== 1'b0) begin
            n_bad++; $display("FAIL mid_idle: wr=%b rd=%b required 0 0", control_memwrite, control_memread);
        end
        tick();
        n_cmp++;
        if (GNT0 !== 1'b1 || GNT1 !== 1'b0) begin
            n_bad++; $display("FAIL mid_ptr: gnt0=%b gnt1=%b required 1 0", GNT0, GNT1);
        end
        @(negedge CLOCK);
        REQ0 = 1'b0;
        tick();
        n_cmp++;
        if (GNT1 !== 1'b1 || RVALID0 !== 1'b1 || RDATA !== 64'h5555) begin
            n_bad++; $display("FAIL mid_overlap: gnt1=%b rv0=%b rdata=%h required 1 1 5555",
                              GNT1, RVALID0, RDATA);
        end
        @(negedge CLOCK);
        REQ1 = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 64'h0;
            tick();
            @(negedge CLOCK);
            REQ0 = 1'b0;
            tick();
            @(negedge CLOCK);
        end
        n_cmp++;
        if (sat_cnt0 !== 2'd3 || sat_cnt1 !== 2'd0) begin
            n_bad++; $display("FAIL sat_cnt: cnt0=%0d cnt1=%0d required 3 0", sat_cnt0, sat_cnt1);
        end
        n_cmp++;
        if (GNT_CNT0 !== 16'd5) begin
            n_bad++; $display("FAIL wide_cnt: cnt0=%0d required 5", GNT_CNT0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_single_read();
        test_contention();
        test_blocked();
        test_reset_mid_access();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
